// File: rtl/dmem_arb_pkg.sv
// Shared encodings, FSM state type and alignment helper for the dmem arbiter.
package dmem_arb_pkg;

  localparam logic [1:0] DS_BYTE = 2'b00;
  localparam logic [1:0] DS_HALF = 2'b01;
  localparam logic [1:0] DS_RSVD = 2'b10;
  localparam logic [1:0] DS_WORD = 2'b11;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP,
    ST_ERR
  } state_e;

  // True when the access size cannot be issued at this byte offset.
  function automatic logic misaligned(input logic [1:0] addr_lo, input logic [1:0] dsize);
    logic bad;
    bad = 1'b0;
    if (dsize == DS_RSVD)      bad = 1'b1;
    else if (dsize == DS_HALF) bad = addr_lo[0];
    else if (dsize == DS_WORD) bad = (addr_lo != 2'b00);
    return bad;
  endfunction

endpackage

// File: rtl/dmem_arb_if.sv
// Requester ports and dmem-side bus of the dmem arbiter.
interface dmem_arb_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          p0_req;
  logic          p0_we;
  logic [1:0]    p0_dsize;
  logic [AW-1:0] p0_addr;
  logic [DW-1:0] p0_wdata;
  logic          p0_ack;
  logic          p0_err;
  logic [DW-1:0] p0_rdata;

  logic          p1_req;
  logic          p1_we;
  logic [1:0]    p1_dsize;
  logic [AW-1:0] p1_addr;
  logic [DW-1:0] p1_wdata;
  logic          p1_ack;
  logic          p1_err;
  logic [DW-1:0] p1_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [1:0]    mem_dsize;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  p0_req, p0_we, p0_dsize, p0_addr, p0_wdata,
    output p0_ack, p0_err, p0_rdata,
    input  p1_req, p1_we, p1_dsize, p1_addr, p1_wdata,
    output p1_ack, p1_err, p1_rdata,
    output mem_en, mem_we, mem_dsize, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output p0_req, p0_we, p0_dsize, p0_addr, p0_wdata,
    input  p0_ack, p0_err, p0_rdata,
    output p1_req, p1_we, p1_dsize, p1_addr, p1_wdata,
    input  p1_ack, p1_err, p1_rdata,
    input  mem_en, mem_we, mem_dsize, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter_rr.sv
// Combinational two-way round-robin picker; the caller owns last_grant.
module rr_arbiter_2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_c_o
);

  // On a tie the port that did not win last time is favoured.
  always_comb begin
    grant_c_o = req_i;
    if (&req_i) grant_c_o = last_grant_i ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of the single-ported data memory.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  dmem_arb_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

  state_e           state_q;
  logic             last_grant_q;
  logic             winner_q;
  logic             we_q;
  logic [CNT_W-1:0] cnt_q;
  logic             p0_ack_q, p0_err_q, p1_ack_q, p1_err_q;
  logic [DW-1:0]    p0_rdata_q, p1_rdata_q;
  logic             mem_en_q, mem_we_q;
  logic [1:0]       mem_dsize_q;
  logic [AW-1:0]    mem_addr_q;
  logic [DW-1:0]    mem_wdata_q;

  logic [1:0]    req_c;
  logic [1:0]    grant_c;
  logic          win_c;
  logic          sel_we_c;
  logic [1:0]    sel_dsize_c;
  logic [AW-1:0] sel_addr_c;
  logic [DW-1:0] sel_wdata_c;

  assign req_c = {bus.p1_req, bus.p0_req};

  rr_arbiter_2 u_rr (
    .req_i        (req_c),
    .last_grant_i (last_grant_q),
    .grant_c_o    (grant_c)
  );

  // Winning port's request fields, only meaningful while some req is high.
  assign win_c       = grant_c[1];
  assign sel_we_c    = win_c ? bus.p1_we    : bus.p0_we;
  assign sel_dsize_c = win_c ? bus.p1_dsize : bus.p0_dsize;
  assign sel_addr_c  = win_c ? bus.p1_addr  : bus.p0_addr;
  assign sel_wdata_c = win_c ? bus.p1_wdata : bus.p0_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      winner_q     <= 1'b0;
      we_q         <= 1'b0;
      cnt_q        <= '0;
      p0_ack_q     <= 1'b0;
      p0_err_q     <= 1'b0;
      p1_ack_q     <= 1'b0;
      p1_err_q     <= 1'b0;
      p0_rdata_q   <= '0;
      p1_rdata_q   <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_dsize_q  <= DS_WORD;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (|req_c) begin
            winner_q     <= win_c;
            last_grant_q <= win_c;
            we_q         <= sel_we_c;
            if (misaligned(sel_addr_c[1:0], sel_dsize_c)) begin
              // Rejected: acknowledge next cycle without touching memory.
              state_q  <= ST_ERR;
              p0_ack_q <= ~win_c;
              p0_err_q <= ~win_c;
              p1_ack_q <= win_c;
              p1_err_q <= win_c;
            end else begin
              state_q     <= ST_ISSUE;
              mem_en_q    <= 1'b1;
              mem_we_q    <= sel_we_c;
              mem_dsize_q <= sel_dsize_c;
              mem_addr_q  <= sel_addr_c;
              mem_wdata_q <= sel_wdata_c;
            end
          end
        end
        ST_ISSUE: begin
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
          cnt_q    <= CNT_INIT;
          state_q  <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt_q == '0) begin
            if (!we_q) begin
              if (winner_q) p1_rdata_q <= bus.mem_rdata;
              else          p0_rdata_q <= bus.mem_rdata;
            end
            p0_ack_q <= ~winner_q;
            p1_ack_q <= winner_q;
            state_q  <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_RESP, ST_ERR: begin
          p0_ack_q <= 1'b0;
          p0_err_q <= 1'b0;
          p1_ack_q <= 1'b0;
          p1_err_q <= 1'b0;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.p0_ack    = p0_ack_q;
  assign bus.p0_err    = p0_err_q;
  assign bus.p0_rdata  = p0_rdata_q;
  assign bus.p1_ack    = p1_ack_q;
  assign bus.p1_err    = p1_err_q;
  assign bus.p1_rdata  = p1_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_dsize = mem_dsize_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: one instance at MEM_LAT=1, one at MEM_LAT=4.
module tb_dmem_arbiter;

  logic clk;
  logic rst_n1, rst_n4;
  int   cyc;
  int   checks;
  int   errors;

  dmem_arb_if #(.AW(32), .DW(32)) b1 ();
  dmem_arb_if #(.AW(32), .DW(32)) b4 ();

  dmem_arbiter #(.MEM_LAT(1), .AW(32), .DW(32)) u_dut1 (.clk(clk), .rst_n(rst_n1), .bus(b1));
  dmem_arbiter #(.MEM_LAT(4), .AW(32), .DW(32)) u_dut4 (.clk(clk), .rst_n(rst_n4), .bus(b4));

  typedef struct {
    int          port;
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  typedef struct {
    logic        we;
    logic [1:0]  ds;
    logic [31:0] addr;
    logic [31:0] wd;
    int          cyc;
  } mexp_t;

  exp_t        expq1[$], expq4[$];
  mexp_t       mq1[$], mq4[$];
  logic [31:0] rdm [2][2];
  int          lat [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic void chk(int k, string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc=%0d: got %h expected %h", name, k, cyc, act, exp);
    end
  endfunction

  function automatic void push_exp(int k, int port, logic err, logic we, logic [31:0] memval, int ecyc);
    exp_t e;
    if (!err && !we) rdm[k][port] = memval;
    e.port  = port;
    e.err   = err;
    e.rdata = rdm[k][port];
    e.cyc   = ecyc;
    if (k == 0) expq1.push_back(e);
    else        expq4.push_back(e);
  endfunction

  function automatic void push_mem(int k, logic we, logic [1:0] ds, logic [31:0] addr, logic [31:0] wd, int ecyc);
    mexp_t m;
    m.we = we; m.ds = ds; m.addr = addr; m.wd = wd; m.cyc = ecyc;
    if (k == 0) mq1.push_back(m);
    else        mq4.push_back(m);
  endfunction

  // Pops the scoreboard whenever an instance shows an ack or a memory strobe.
  function automatic void mon(int k, logic a0, logic a1, logic e0, logic e1,
                              logic [31:0] r0, logic [31:0] r1, logic men, logic mwe,
                              logic [1:0] mds, logic [31:0] mad, logic [31:0] mwd);
    exp_t  e;
    mexp_t m;
    if (a0 || a1) begin
      chk(k, "one_ack", 32'(a0 & a1), 0);
      if ((k == 0 && expq1.size() == 0) || (k == 1 && expq4.size() == 0)) begin
        checks++; errors++;
        $display("FAIL unexpected_ack dut%0d cyc=%0d: got ack p0=%0b p1=%0b expected none", k, cyc, a0, a1);
      end else begin
        e = (k == 0) ? expq1.pop_front() : expq4.pop_front();
        chk(k, "ack_port",  32'(a1), 32'(e.port));
        chk(k, "ack_err",   32'(a1 ? e1 : e0), 32'(e.err));
        chk(k, "idle_err",  32'(a1 ? e0 : e1), 0);
        chk(k, "ack_cycle", 32'(cyc), 32'(e.cyc));
        chk(k, "rdata",     a1 ? r1 : r0, e.rdata);
      end
    end
    if (men) begin
      if ((k == 0 && mq1.size() == 0) || (k == 1 && mq4.size() == 0)) begin
        checks++; errors++;
        $display("FAIL unexpected_mem_en dut%0d cyc=%0d: got mem_en=1 addr=%h expected 0", k, cyc, mad);
      end else begin
        m = (k == 0) ? mq1.pop_front() : mq4.pop_front();
        chk(k, "mem_we",    32'(mwe), 32'(m.we));
        chk(k, "mem_dsize", 32'(mds), 32'(m.ds));
        chk(k, "mem_addr",  mad, m.addr);
        chk(k, "mem_wdata", mwd, m.wd);
        chk(k, "mem_cycle", 32'(cyc), 32'(m.cyc));
      end
    end else if (mwe) begin
      chk(k, "mem_we_unqualified", 32'(mwe), 0);
    end
  endfunction

  always @(negedge clk) begin
    mon(0, b1.p0_ack, b1.p1_ack, b1.p0_err, b1.p1_err, b1.p0_rdata, b1.p1_rdata,
        b1.mem_en, b1.mem_we, b1.mem_dsize, b1.mem_addr, b1.mem_wdata);
    mon(1, b4.p0_ack, b4.p1_ack, b4.p0_err, b4.p1_err, b4.p0_rdata, b4.p1_rdata,
        b4.mem_en, b4.mem_we, b4.mem_dsize, b4.mem_addr, b4.mem_wdata);
  end

  function automatic void chk_rst(int k, logic a0, logic a1, logic e0, logic e1, logic men, logic mwe,
                                  logic [1:0] mds, logic [31:0] mad, logic [31:0] mwd,
                                  logic [31:0] r0, logic [31:0] r1);
    chk(k, "rst_acks",      32'({a1, a0}), 0);
    chk(k, "rst_errs",      32'({e1, e0}), 0);
    chk(k, "rst_mem_en_we", 32'({men, mwe}), 0);
    chk(k, "rst_mem_dsize", 32'(mds), 3);
    chk(k, "rst_mem_addr",  mad, 0);
    chk(k, "rst_mem_wdata", mwd, 0);
    chk(k, "rst_rdata",     r0 | r1, 0);
  endfunction

  task automatic set_req(int k, int port, logic v);
    if (k == 0) begin
      if (port == 0) b1.p0_req = v; else b1.p1_req = v;
    end else begin
      if (port == 0) b4.p0_req = v; else b4.p1_req = v;
    end
  endtask

  task automatic set_fields(int k, int port, logic we, logic [1:0] ds, logic [31:0] addr, logic [31:0] wd);
    if (k == 0 && port == 0) begin b1.p0_we = we; b1.p0_dsize = ds; b1.p0_addr = addr; b1.p0_wdata = wd; end
    if (k == 0 && port == 1) begin b1.p1_we = we; b1.p1_dsize = ds; b1.p1_addr = addr; b1.p1_wdata = wd; end
    if (k == 1 && port == 0) begin b4.p0_we = we; b4.p0_dsize = ds; b4.p0_addr = addr; b4.p0_wdata = wd; end
    if (k == 1 && port == 1) begin b4.p1_we = we; b4.p1_dsize = ds; b4.p1_addr = addr; b4.p1_wdata = wd; end
  endtask

  task automatic wait_ack(int k, int port);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (k == 0) seen = (port == 0) ? b1.p0_ack : b1.p1_ack;
      else        seen = (port == 0) ? b4.p0_ack : b4.p1_ack;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL ack_timeout dut%0d port%0d: got no ack expected ack within 40 cycles", k, port);
    end
  endtask

  // Single-port transaction: request, await its ack, then release the request.
  task automatic do_txn(int k, int port, logic we, logic [1:0] ds, logic [31:0] addr,
                        logic [31:0] wd, logic [31:0] memval, logic err);
    @(posedge clk); #1;
    set_fields(k, port, we, ds, addr, wd);
    if (k == 0) b1.mem_rdata = memval; else b4.mem_rdata = memval;
    set_req(k, port, 1'b1);
    push_exp(k, port, err, we, memval, cyc + (err ? 1 : lat[k] + 2));
    if (!err) push_mem(k, we, ds, addr, wd, cyc + 1);
    wait_ack(k, port);
    @(posedge clk); #1;
    set_req(k, port, 1'b0);
  endtask

  initial begin
    int t;
    checks = 0; errors = 0; cyc = 0;
    lat[0] = 1; lat[1] = 4;
    for (int k = 0; k < 2; k++) for (int p = 0; p < 2; p++) rdm[k][p] = '0;
    rst_n1 = 1'b0; rst_n4 = 1'b0;
    for (int k = 0; k < 2; k++) for (int p = 0; p < 2; p++) begin
      set_req(k, p, 1'b0);
      set_fields(k, p, 1'b0, 2'b11, 32'h0, 32'h0);
    end
    b1.mem_rdata = '0; b4.mem_rdata = '0;

    repeat (2) @(posedge clk); #1;
    chk_rst(0, b1.p0_ack, b1.p1_ack, b1.p0_err, b1.p1_err, b1.mem_en, b1.mem_we,
            b1.mem_dsize, b1.mem_addr, b1.mem_wdata, b1.p0_rdata, b1.p1_rdata);
    chk_rst(1, b4.p0_ack, b4.p1_ack, b4.p0_err, b4.p1_err, b4.mem_en, b4.mem_we,
            b4.mem_dsize, b4.mem_addr, b4.mem_wdata, b4.p0_rdata, b4.p1_rdata);
    rst_n1 = 1'b1; rst_n4 = 1'b1;

    // Both ports hold requests from reset: p0 first, then strict alternation.
    @(posedge clk); #1;
    t = cyc;
    set_fields(0, 0, 1'b0, 2'b11, 32'h100, 32'h0);
    set_fields(0, 1, 1'b0, 2'b11, 32'h104, 32'h0);
    b1.mem_rdata = 32'h1111_2222;
    set_req(0, 0, 1'b1); set_req(0, 1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      push_exp(0, i % 2, 1'b0, 1'b0, 32'h1111_2222, t + 3 + 4 * i);
      push_mem(0, 1'b0, 2'b11, (i % 2 == 0) ? 32'h100 : 32'h104, 32'h0, t + 1 + 4 * i);
    end
    repeat (16) @(posedge clk); #1;
    set_req(0, 0, 1'b0); set_req(0, 1, 1'b0);

    do_txn(0, 0, 1'b0, 2'b11, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
    do_txn(0, 1, 1'b1, 2'b01, 32'h21, 32'h1234, 32'h0, 1'b1);
    do_txn(0, 0, 1'b1, 2'b10, 32'h0, 32'h55, 32'h0, 1'b1);
    do_txn(0, 0, 1'b1, 2'b00, 32'h13, 32'h0000_00A5, 32'hFFFF_FFFF, 1'b0);
    do_txn(0, 1, 1'b0, 2'b11, 32'h8, 32'h0, 32'h1234_5678, 1'b0);
    do_txn(0, 0, 1'b0, 2'b01, 32'h2, 32'h0, 32'h0000_BEEF, 1'b0);
    do_txn(0, 1, 1'b0, 2'b11, 32'h6, 32'h0, 32'h0, 1'b1);

    do_txn(1, 1, 1'b0, 2'b11, 32'h40, 32'h0, 32'hCAFE_F00D, 1'b0);

    // Request withdrawn while the access is in flight still completes.
    @(posedge clk); #1;
    t = cyc;
    set_fields(1, 0, 1'b0, 2'b11, 32'h44, 32'h0);
    b4.mem_rdata = 32'h0BAD_F00D;
    set_req(1, 0, 1'b1);
    push_exp(1, 0, 1'b0, 1'b0, 32'h0BAD_F00D, t + 6);
    push_mem(1, 1'b0, 2'b11, 32'h44, 32'h0, t + 1);
    repeat (2) @(posedge clk); #1;
    set_req(1, 0, 1'b0);
    set_fields(1, 0, 1'b1, 2'b10, 32'h99, 32'hFFFF_FFFF);
    wait_ack(1, 0);

    // Reset while waiting on memory abandons the transaction.
    @(posedge clk); #1;
    set_fields(1, 1, 1'b0, 2'b11, 32'h48, 32'h0);
    set_req(1, 1, 1'b1);
    push_mem(1, 1'b0, 2'b11, 32'h48, 32'h0, cyc + 1);
    repeat (3) @(posedge clk); #1;
    rst_n4 = 1'b0;
    set_req(1, 1, 1'b0);
    expq4.delete();
    rdm[1][0] = '0; rdm[1][1] = '0;
    #1;
    chk_rst(1, b4.p0_ack, b4.p1_ack, b4.p0_err, b4.p1_err, b4.mem_en, b4.mem_we,
            b4.mem_dsize, b4.mem_addr, b4.mem_wdata, b4.p0_rdata, b4.p1_rdata);
    @(posedge clk); #1;
    rst_n4 = 1'b1;

    do_txn(1, 1, 1'b0, 2'b11, 32'h50, 32'h0, 32'h5555_AAAA, 1'b0);

    @(posedge clk); #1;
    t = cyc;
    set_fields(1, 0, 1'b0, 2'b11, 32'h60, 32'h0);
    set_fields(1, 1, 1'b0, 2'b11, 32'h64, 32'h0);
    b4.mem_rdata = 32'h7777_8888;
    set_req(1, 0, 1'b1); set_req(1, 1, 1'b1);
    push_exp(1, 0, 1'b0, 1'b0, 32'h7777_8888, t + 6);
    push_mem(1, 1'b0, 2'b11, 32'h60, 32'h0, t + 1);
    push_exp(1, 1, 1'b0, 1'b0, 32'h7777_8888, t + 13);
    push_mem(1, 1'b0, 2'b11, 32'h64, 32'h0, t + 8);
    repeat (14) @(posedge clk); #1;
    set_req(1, 0, 1'b0); set_req(1, 1, 1'b0);

    repeat (6) @(posedge clk); #1;
    chk(0, "pending_acks", 32'(expq1.size() + expq4.size()), 0);
    chk(0, "pending_mem",  32'(mq1.size() + mq4.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-ported data memory (dmem) between two requesters: port 0 is the CPU load/store path, port 1 is a secondary master (debug/DMA loader).
- Performs two-way round-robin arbitration, one transaction at a time, with a fixed-latency memory sequence.
- Checks sub-word alignment before any access and returns an error acknowledge instead of touching memory.
- Sits between the datapath's ALU-address/busB store-data path and the dmem instance.

Parameters:
- MEM_LAT, 1, cycles from the mem_en cycle to valid mem_rdata; legal range 1..15.
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- p0_req  in  1  port 0 request; held with its fields until p0_ack.
- p0_we  in  1  1 = store, 0 = load.
- p0_dsize  in  2  00 byte, 01 half, 11 word, 10 reserved.
- p0_addr  in  AW  byte address.
- p0_wdata  in  DW  store data, right-justified.
- p0_ack  out  1  one-cycle completion pulse.
- p0_err  out  1  valid with p0_ack; 1 = rejected, no memory access.
- p0_rdata  out  DW  load data, valid with p0_ack; holds its value otherwise.
- p1_req, p1_we, p1_dsize, p1_addr, p1_wdata, p1_ack, p1_err, p1_rdata: identical set for port 1.
- mem_en  out  1  one-cycle access strobe.
- mem_we  out  1  write enable, qualified by mem_en.
- mem_dsize  out  2  access size to dmem.
- mem_addr  out  AW  address to dmem.
- mem_wdata  out  DW  write data to dmem.
- mem_rdata  in  DW  read data from dmem.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; all acks, errs, mem_en and mem_we = 0.
  - rdata, mem_addr, mem_wdata = 0; mem_dsize=11.
  - last_grant=1, so port 0 wins the first tie.
- FSM states: IDLE, ISSUE, WAIT, RESP, ERR.
- IDLE:
  - If any req is high, pick a winner and latch its we, dsize, addr, wdata and the winning port id.
  - Exactly one request wins; if both request, the port != last_grant wins.
  - Set last_grant to the winner.
  - If dsize=10, or half-word with addr[0]=1, or word with addr[1:0]!=0: go to ERR. Otherwise go to ISSUE.
- ISSUE: mem_en=1 and mem_we=latched we for exactly one cycle; mem_addr, mem_dsize and mem_wdata are driven from the latch. Go to WAIT and load cnt=MEM_LAT-1.
- WAIT:
  - If cnt==0, capture mem_rdata into the winner's rdata register (loads only; on stores the register is unchanged) and go to RESP.
  - Otherwise cnt decrements.
- RESP: winner's ack=1 and err=0 for one cycle; go to IDLE.
- ERR: winner's ack=1 and err=1 for one cycle, with no mem_en; go to IDLE.
- Latency:
  - req seen in IDLE at cycle 0 → mem_en at cycle 1 → ack at cycle MEM_LAT+2.
  - Error ack at cycle 1.
  - Back-to-back throughput is one transaction per MEM_LAT+3 cycles.
- Request rules:
  - A req still high in the cycle after its ack is a new request.
  - A req dropped mid-transaction does not cancel it; the ack is still pulsed.
  - Changes to a losing port's fields while it waits are permitted; they are sampled only when it wins.
- Only one ack is high in any cycle; the non-winning port's ack/err stay 0.
- mem_addr, mem_dsize and mem_wdata hold their values outside ISSUE; mem_we is 0 whenever mem_en is 0.
- Reset mid-transaction: the transaction is abandoned with no ack. A write already strobed may have completed in dmem; no rollback.
- Simultaneous request arriving in the RESP cycle: it is sampled in the following IDLE cycle.

Decomposition:
- Package dmem_arb_pkg:
  - dsize encodings: DS_BYTE=2'b00, DS_HALF=2'b01, DS_RSVD=2'b10, DS_WORD=2'b11.
  - FSM state enum.
  - function misaligned(addr[1:0], dsize).
- Sub-module rr_arbiter_2: combinational two-way round-robin picker (req[1:0], last_grant → grant[1:0]). The FSM owns the last_grant register.

Test Plan:
- MEM_LAT=1; p0 word load, addr=0x10, mem_rdata=0xDEADBEEF → mem_en in cycle 1 with mem_addr=0x10, mem_we=0; p0_ack=1, p0_err=0, p0_rdata=0xDEADBEEF in cycle 3.
- p0 and p1 both hold req after reset → grants in order p0, p1, p0, p1; acks alternate every MEM_LAT+3 cycles; never both high.
- p1 half store, addr=0x21 → p1_ack=1, p1_err=1 in cycle 1; mem_en never asserted. Same for p0_dsize=10 at addr=0x0.
- p0 byte store, addr=0x13, wdata=0x000000A5 → mem_en=1, mem_we=1, mem_dsize=00, mem_addr=0x13, mem_wdata=0xA5; p0_rdata unchanged.
- MEM_LAT=4; p1 load → ack exactly 6 cycles after req; p0_req dropped to 0 in cycle 2 still gets its ack when p0 was the winner.
- Assert reset during WAIT → mem_en and all acks 0 immediately. After release, a p1-only request is granted, and a later tie goes to p0 (last_grant reset to 1).
